// File: rtl/ysyx_25040118_mem_arbiter_if.sv
// Bundle of IFU, LSU and memory-side signals around the shared memory port.
// master: the arbiter itself; slave: the clients and memory adapter facing it.
interface ysyx_25040118_mem_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        ifu_resp_err;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_we;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        lsu_resp_err;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    modport master (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_25040118_mem_arbiter.sv
// IFU/LSU arbiter for the single memory port: round-robin on ties, one
// outstanding transaction, responses routed to the owner, timeout error.
module ysyx_25040118_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_25040118_mem_arbiter_if.master   bus
);
    localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state_reg;
    logic          owner_reg;
    logic          last_grant_reg;
    logic          mem_req_valid_reg;
    logic          we_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [3:0]    wmask_reg;
    logic [CW-1:0] cnt_reg;

    // Per-master views, index 0 = IFU, 1 = LSU.
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wmask [2];
    logic [1:0]  grant;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_err;
    logic [31:0] resp_rdata [2];

    logic idle_now;
    logic in_resp;
    logic timed_out;
    logic resp_fire;
    logic sel;

    assign req_valid    = {bus.lsu_req_valid, bus.ifu_req_valid};
    assign req_we       = {bus.lsu_we, 1'b0};
    assign req_addr[0]  = bus.ifu_addr;
    assign req_addr[1]  = bus.lsu_addr;
    assign req_wdata[0] = '0;
    assign req_wdata[1] = bus.lsu_wdata;
    assign req_wmask[0] = '0;
    assign req_wmask[1] = bus.lsu_wmask;

    // Outputs are gated by rst so the reset cycle itself presents a quiet port.
    assign idle_now  = (state_reg == IDLE) && !rst;
    assign in_resp   = (state_reg == RESP) && !rst;
    assign timed_out = (cnt_reg == CNT_MAX);
    assign resp_fire = in_resp && (bus.mem_resp_valid || timed_out);
    assign sel       = grant[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign grant[gi]      = idle_now && req_valid[gi] &&
                                    (!req_valid[1-gi] || (last_grant_reg != 1'(gi)));
            assign resp_valid[gi] = resp_fire && (owner_reg == 1'(gi));
            assign resp_err[gi]   = resp_valid[gi] && !bus.mem_resp_valid;
            assign resp_rdata[gi] = (resp_valid[gi] && bus.mem_resp_valid) ? bus.mem_rdata : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            owner_reg         <= 1'b0;
            last_grant_reg    <= 1'b0;
            mem_req_valid_reg <= 1'b0;
            we_reg            <= 1'b0;
            addr_reg          <= '0;
            wdata_reg         <= '0;
            wmask_reg         <= '0;
            cnt_reg           <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|grant) begin
                        owner_reg         <= sel;
                        last_grant_reg    <= sel;
                        we_reg            <= req_we[sel];
                        addr_reg          <= req_addr[sel];
                        wdata_reg         <= req_wdata[sel];
                        wmask_reg         <= req_wmask[sel];
                        mem_req_valid_reg <= 1'b1;
                        state_reg         <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        cnt_reg           <= '0;
                        mem_req_valid_reg <= 1'b0;
                        state_reg         <= RESP;
                    end
                end
                RESP: begin
                    if (resp_fire) begin
                        state_reg <= IDLE;
                    end else if (!timed_out) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg         <= IDLE;
                    mem_req_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ifu_req_ready  = grant[0];
    assign bus.lsu_req_ready  = grant[1];
    assign bus.ifu_resp_valid = resp_valid[0];
    assign bus.lsu_resp_valid = resp_valid[1];
    assign bus.ifu_resp_err   = resp_err[0];
    assign bus.lsu_resp_err   = resp_err[1];
    assign bus.ifu_rdata      = resp_rdata[0];
    assign bus.lsu_rdata      = resp_rdata[1];

    assign bus.mem_req_valid  = mem_req_valid_reg && !rst;
    assign bus.mem_we         = we_reg && !rst;
    assign bus.mem_addr       = rst ? '0 : addr_reg;
    assign bus.mem_wdata      = rst ? '0 : wdata_reg;
    assign bus.mem_wmask      = rst ? '0 : wmask_reg;
endmodule

// File: tb/tb_ysyx_25040118_mem_arbiter.sv
// Directed bench for the memory arbiter; responses are checked against a
// scoreboard filled when each request is accepted.
module tb_ysyx_25040118_mem_arbiter;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_25040118_mem_arbiter_if bus();

    ysyx_25040118_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        owner;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic push(input logic owner, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.owner = owner;
        e.rdata = rdata;
        e.err   = err;
        sb_q.push_back(e);
    endtask

    task automatic clear_inputs();
        bus.ifu_req_valid  = 1'b0;
        bus.ifu_addr       = '0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_we         = 1'b0;
        bus.lsu_addr       = '0;
        bus.lsu_wdata      = '0;
        bus.lsu_wmask      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.ifu_resp_valid === 1'b1 || bus.lsu_resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", {30'b0, bus.lsu_resp_valid, bus.ifu_resp_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("t=%0t resp %s rdata=%h err=%b", $time, e.owner ? "LSU" : "IFU",
                         e.owner ? bus.lsu_rdata : bus.ifu_rdata,
                         e.owner ? bus.lsu_resp_err : bus.ifu_resp_err);
                chk("resp_route", {30'b0, bus.lsu_resp_valid, bus.ifu_resp_valid},
                    e.owner ? 32'd2 : 32'd1);
                chk("resp_rdata", e.owner ? bus.lsu_rdata : bus.ifu_rdata, e.rdata);
                chk("resp_err", {31'b0, e.owner ? bus.lsu_resp_err : bus.ifu_resp_err},
                    {31'b0, e.err});
                chk("nonowner_rdata", e.owner ? bus.ifu_rdata : bus.lsu_rdata, 32'd0);
                chk("nonowner_err", {31'b0, e.owner ? bus.ifu_resp_err : bus.lsu_resp_err}, 32'd0);
            end
        end else begin
            chk("quiet_rdata", bus.ifu_rdata | bus.lsu_rdata, 32'd0);
            chk("quiet_err", {31'b0, bus.ifu_resp_err | bus.lsu_resp_err}, 32'd0);
        end
    end

    initial begin
        rst = 1'b1;
        clear_inputs();

        // Reset with both masters requesting: nothing may be granted.
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        step();
        settle();
        chk("rst_ifu_ready", bus.ifu_req_ready, 32'd0);
        chk("rst_lsu_ready", bus.lsu_req_ready, 32'd0);
        chk("rst_mem_valid", bus.mem_req_valid, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_we_mask", {27'b0, bus.mem_we, bus.mem_wmask}, 32'd0);
        chk("rst_resp_valid", {30'b0, bus.lsu_resp_valid, bus.ifu_resp_valid}, 32'd0);

        step();
        rst = 1'b0;
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        settle();
        chk("post_rst_mem_valid", bus.mem_req_valid, 32'd0);
        chk("post_rst_mem_addr", bus.mem_addr, 32'd0);

        // Tie after reset: LSU first, then IFU, then LSU again.
        step();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0004;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_0200;
        bus.mem_req_ready = 1'b1;
        settle();
        chk("tie1_lsu_ready", bus.lsu_req_ready, 32'd1);
        chk("tie1_ifu_ready", bus.ifu_req_ready, 32'd0);
        push(1'b1, 32'h1111_0001, 1'b0);
        step();
        bus.lsu_req_valid = 1'b0;
        settle();
        chk("tie1_mem_addr", bus.mem_addr, 32'h8000_0200);
        chk("tie1_req_ifu_ready", bus.ifu_req_ready, 32'd0);
        step();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1111_0001;
        settle();
        chk("tie1_resp", bus.lsu_resp_valid, 32'd1);
        chk("no_accept_on_resp", bus.ifu_req_ready, 32'd0);
        step();
        bus.mem_resp_valid = 1'b0;
        bus.lsu_req_valid  = 1'b1;
        settle();
        chk("tie2_ifu_ready", bus.ifu_req_ready, 32'd1);
        chk("tie2_lsu_ready", bus.lsu_req_ready, 32'd0);
        push(1'b0, 32'h2222_0002, 1'b0);
        step();
        bus.ifu_req_valid = 1'b0;
        settle();
        chk("tie2_mem_addr", bus.mem_addr, 32'h8000_0004);
        step();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h2222_0002;
        settle();
        chk("tie2_resp", bus.ifu_resp_valid, 32'd1);
        step();
        bus.mem_resp_valid = 1'b0;
        bus.ifu_req_valid  = 1'b1;
        settle();
        chk("tie3_lsu_ready", bus.lsu_req_ready, 32'd1);
        chk("tie3_ifu_ready", bus.ifu_req_ready, 32'd0);
        push(1'b1, 32'h3333_0003, 1'b0);
        step();
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        settle();
        step();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h3333_0003;
        settle();
        chk("tie3_resp", bus.lsu_resp_valid, 32'd1);
        step();
        bus.mem_resp_valid = 1'b0;
        settle();

        // IFU-only read at minimum latency.
        step();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0000;
        settle();
        chk("ifu_ready", bus.ifu_req_ready, 32'd1);
        push(1'b0, 32'h0000_0413, 1'b0);
        step();
        bus.ifu_req_valid = 1'b0;
        settle();
        chk("ifu_mem_valid", bus.mem_req_valid, 32'd1);
        chk("ifu_mem_addr", bus.mem_addr, 32'h8000_0000);
        chk("ifu_mem_we_mask", {27'b0, bus.mem_we, bus.mem_wmask}, 32'd0);
        step();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_0413;
        settle();
        chk("ifu_resp_c2", bus.ifu_resp_valid, 32'd1);
        chk("ifu_resp_mem_valid", bus.mem_req_valid, 32'd0);
        step();
        bus.mem_resp_valid = 1'b0;
        settle();
        chk("ifu_resp_pulse_end", bus.ifu_resp_valid, 32'd0);

        // LSU store byte with mem_req_ready held low for three cycles.
        step();
        bus.mem_req_ready = 1'b0;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_we        = 1'b1;
        bus.lsu_addr      = 32'h8000_0101;
        bus.lsu_wdata     = 32'h0000_AB00;
        bus.lsu_wmask     = 4'b0010;
        settle();
        chk("st_ready", bus.lsu_req_ready, 32'd1);
        push(1'b1, 32'h5A5A_1234, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            bus.lsu_req_valid = 1'b0;
            bus.lsu_we        = 1'b0;
            bus.lsu_addr      = 32'hFFFF_FFF0 + 32'(i);
            bus.lsu_wdata     = 32'hDEAD_0000 + 32'(i);
            bus.lsu_wmask     = 4'b1111;
            settle();
            chk("st_mem_valid", bus.mem_req_valid, 32'd1);
            chk("st_mem_addr", bus.mem_addr, 32'h8000_0101);
            chk("st_mem_wdata", bus.mem_wdata, 32'h0000_AB00);
            chk("st_mem_we_mask", {27'b0, bus.mem_we, bus.mem_wmask}, 32'h12);
        end
        step();
        bus.mem_req_ready = 1'b1;
        settle();
        chk("st_hold_valid", bus.mem_req_valid, 32'd1);
        step();
        bus.mem_req_ready = 1'b0;
        settle();
        chk("st_wait_no_resp", bus.lsu_resp_valid, 32'd0);
        chk("st_resp_mem_valid", bus.mem_req_valid, 32'd0);
        step();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h5A5A_1234;
        settle();
        chk("st_ack", bus.lsu_resp_valid, 32'd1);
        step();
        bus.mem_resp_valid = 1'b0;
        settle();
        chk("st_ack_once", bus.lsu_resp_valid, 32'd0);

        // Timeout on an IFU read, followed by a stray memory response.
        step();
        bus.mem_req_ready = 1'b1;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0010;
        settle();
        push(1'b0, 32'h0, 1'b1);
        step();
        bus.ifu_req_valid = 1'b0;
        settle();
        for (int i = 0; i < TO; i++) begin
            step();
            settle();
            chk("to_wait", bus.ifu_resp_valid, 32'd0);
        end
        step();
        settle();
        chk("to_fire", bus.ifu_resp_valid, 32'd1);
        chk("to_err", bus.ifu_resp_err, 32'd1);
        step();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hFFFF_0000;
        settle();
        chk("stray_ignored", {30'b0, bus.lsu_resp_valid, bus.ifu_resp_valid}, 32'd0);
        step();
        bus.mem_resp_valid = 1'b0;
        settle();

        // Memory response on the very cycle the timeout would fire.
        step();
        bus.lsu_req_valid = 1'b1;
        bus.lsu_we        = 1'b0;
        bus.lsu_addr      = 32'h8000_0300;
        bus.lsu_wmask     = 4'b0000;
        settle();
        chk("race_ready", bus.lsu_req_ready, 32'd1);
        push(1'b1, 32'hCAFE_F00D, 1'b0);
        step();
        bus.lsu_req_valid = 1'b0;
        settle();
        for (int i = 0; i < TO; i++) begin
            step();
            settle();
            chk("race_wait", bus.lsu_resp_valid, 32'd0);
        end
        step();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hCAFE_F00D;
        settle();
        chk("race_resp", bus.lsu_resp_valid, 32'd1);
        chk("race_err", bus.lsu_resp_err, 32'd0);
        step();
        bus.mem_resp_valid = 1'b0;
        settle();

        // Reset while waiting in RESP drops the transaction.
        step();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0020;
        settle();
        chk("rr_ready", bus.ifu_req_ready, 32'd1);
        step();
        bus.ifu_req_valid = 1'b0;
        settle();
        step();
        settle();
        step();
        rst = 1'b1;
        settle();
        chk("rr_no_resp", bus.ifu_resp_valid, 32'd0);
        chk("rr_mem_valid_rst", bus.mem_req_valid, 32'd0);
        step();
        rst = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0040;
        settle();
        chk("rr_mem_valid_after", bus.mem_req_valid, 32'd0);
        chk("rr_new_accept", bus.ifu_req_ready, 32'd1);
        push(1'b0, 32'h0BAD_CAFE, 1'b0);
        step();
        bus.ifu_req_valid = 1'b0;
        settle();
        chk("rr_mem_addr", bus.mem_addr, 32'h8000_0040);
        step();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0BAD_CAFE;
        settle();
        chk("rr_resp", bus.ifu_resp_valid, 32'd1);
        step();
        bus.mem_resp_valid = 1'b0;
        settle();

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end
endmodule
